// File: rtl/opsum_glb_if.sv
// Opsum stream (valid/ready) and GLB write port bundle.
// The master modport is the write-back engine; slave is the PE array / GLB side.
interface opsum_glb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                     opsum_valid;
  logic                     opsum_ready;
  logic signed [DATA_W-1:0] opsum_data;
  logic                     glb_we;
  logic [3:0]               glb_bwe;
  logic [ADDR_W-1:0]        glb_addr;
  logic [DATA_W-1:0]        glb_wdata;
  logic                     glb_stall;

  modport master (
    input  opsum_valid, opsum_data, glb_stall,
    output opsum_ready, glb_we, glb_bwe, glb_addr, glb_wdata
  );

  modport slave (
    output opsum_valid, opsum_data, glb_stall,
    input  opsum_ready, glb_we, glb_bwe, glb_addr, glb_wdata
  );
endinterface

// File: rtl/opsum_glb_writer.sv
// Drains the PE-array opsum stream into GLB as consecutive little-endian words,
// with a single pending-write register absorbing GLB back-pressure.
module opsum_glb_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              relu_en,
  opsum_glb_if.master       bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  num_r;
  logic              relu_r;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  acc_cnt;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic              launch;
  logic              write_accept;
  logic              can_take;
  logic              accept;
  logic              last_write;

  function automatic logic [DATA_W-1:0] relu_clamp(
    input logic signed [DATA_W-1:0] d,
    input logic                     en
  );
    return (en && d[DATA_W-1]) ? '0 : d;
  endfunction

  assign launch       = start && (state != RUN);
  assign write_accept = vld_p1 && !bus.glb_stall;
  assign can_take     = (state == RUN) && (acc_cnt < num_r);
  // A held write frees the pending slot in the same cycle it is accepted.
  assign bus.opsum_ready = can_take && (!vld_p1 || write_accept);
  assign accept       = bus.opsum_valid && bus.opsum_ready;
  assign last_write   = write_accept && (idx == num_r - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (launch) state_nxt = (num_words == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_write) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: accepted opsum becomes the pending GLB write
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= '0;
      num_r    <= '0;
      relu_r   <= 1'b0;
      idx      <= '0;
      acc_cnt  <= '0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (launch) begin
      base_r  <= base_addr & ~(ADDR_W'(3));
      num_r   <= num_words;
      relu_r  <= relu_en;
      idx     <= '0;
      acc_cnt <= '0;
    end else begin
      if (write_accept) idx <= idx + 1'b1;
      if (accept) begin
        acc_cnt  <= acc_cnt + 1'b1;
        vld_p1   <= 1'b1;
        addr_p1  <= base_r + ADDR_W'({acc_cnt, 2'b00});
        wdata_p1 <= relu_clamp(bus.opsum_data, relu_r);
      end else if (write_accept) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // p1: GLB write port
  assign bus.glb_we    = vld_p1;
  assign bus.glb_bwe   = vld_p1 ? 4'hF : 4'h0;
  assign bus.glb_addr  = addr_p1;
  assign bus.glb_wdata = wdata_p1;

endmodule

// File: tb/tb_opsum_glb_writer.sv
// Bench for opsum_glb_writer: scenario tasks plus randomized jobs checked
// against a GLB byte-memory model and an expected write list.
module tb_opsum_glb_writer;

  logic        clk = 1'b0;
  logic        rst, start, relu_en;
  logic [15:0] base_addr, num_words;
  logic        busy, done;

  opsum_glb_if #(.DATA_W(32), .ADDR_W(16)) bus ();

  opsum_glb_writer #(.DATA_W(32), .ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .relu_en(relu_en), .bus(bus),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_bwe[$];
  int          wq_cyc[$];
  logic [31:0] src[$];

  // GLB model: every write that is not stalled lands in byte memory.
  always @(negedge clk) begin
    if (bus.glb_we && !bus.glb_stall) begin
      wq_addr.push_back(bus.glb_addr);
      wq_data.push_back(bus.glb_wdata);
      wq_bwe.push_back(bus.glb_bwe);
      wq_cyc.push_back(cyc);
      mem[bus.glb_addr]         <= bus.glb_wdata[7:0];
      mem[bus.glb_addr + 16'd1] <= bus.glb_wdata[15:8];
      mem[bus.glb_addr + 16'd2] <= bus.glb_wdata[23:16];
      mem[bus.glb_addr + 16'd3] <= bus.glb_wdata[31:24];
    end
  end

  function automatic logic [15:0] exp_addr(input logic [15:0] base, input int i);
    return (base & 16'hFFFC) + 16'(4 * i);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] d, input logic relu);
    return (relu && $signed(d) < 0) ? 32'h0 : d;
  endfunction

  task automatic clear_writes();
    wq_addr.delete(); wq_data.delete(); wq_bwe.delete(); wq_cyc.delete();
  endtask

  task automatic drive_job(input logic [15:0] base, input logic [15:0] num, input logic relu,
                           input int stall_pct, input int valid_pct, input int mid_start,
                           output int lat, output int dcyc);
    int i;
    bit take;
    i = 0; lat = -1; dcyc = -1;
    @(posedge clk); #1;
    base_addr = base; num_words = num; relu_en = relu; start = 1'b1;
    bus.opsum_valid = 1'b0; bus.glb_stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 500; b++) begin
      bus.opsum_valid = (i < int'(num)) && ($urandom_range(99) < valid_pct);
      bus.opsum_data  = (i < src.size()) ? src[i] : 32'h0;
      bus.glb_stall   = ($urandom_range(99) < stall_pct);
      @(negedge clk);
      if (done) begin lat = b; dcyc = cyc; break; end
      take = bus.opsum_valid && bus.opsum_ready;
      @(posedge clk); #1;
      if (take) i++;
      start = (b == mid_start);
      if (start) begin
        base_addr = base ^ 16'h7770; num_words = num + 16'd3; relu_en = !relu;
      end
    end
    bus.opsum_valid = 1'b0; bus.glb_stall = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; base_addr = '0; num_words = '0;
    bus.opsum_valid = 1'b0; bus.opsum_data = '0; bus.glb_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.opsum_ready, bus.glb_we, bus.glb_bwe, busy, done} !== 8'h0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000000",
                        {bus.opsum_ready, bus.glb_we, bus.glb_bwe, busy, done});
    end
    tests++;
    if ({bus.glb_addr, bus.glb_wdata} !== 48'h0) begin
      fails++; $display("FAIL reset_data: addr %h wdata %h want 0", bus.glb_addr, bus.glb_wdata);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, dcyc;
    clear_writes();
    src = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    drive_job(16'h0100, 16'd4, 1'b0, 0, 100, -1, lat, dcyc);
    tests++;
    if (wq_addr.size() != 4) begin fails++; $display("FAIL basic_count: got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < wq_addr.size() && i < 4; i++) begin
      tests++;
      if (wq_addr[i] !== exp_addr(16'h0100, i) || wq_data[i] !== src[i] || wq_bwe[i] !== 4'hF) begin
        fails++; $display("FAIL basic_word%0d: got %h/%h/%h want %h/%h/f", i,
                          wq_addr[i], wq_data[i], wq_bwe[i], exp_addr(16'h0100, i), src[i]);
      end
      if (i > 0) begin
        tests++;
        if (wq_cyc[i] != wq_cyc[i-1] + 1) begin
          fails++; $display("FAIL basic_b2b%0d: cycle %0d want %0d", i, wq_cyc[i], wq_cyc[i-1] + 1);
        end
      end
    end
    tests++;
    if (wq_cyc.size() == 0 || dcyc != wq_cyc[wq_cyc.size()-1] + 1) begin
      fails++; $display("FAIL basic_done: done cycle %0d, last write not followed by done", dcyc);
    end
    tests++;
    if ({mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]} !== 32'h11111111) begin
      fails++; $display("FAIL basic_mem: got %h%h%h%h want 11111111",
                        mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]);
    end
  endtask

  task automatic test_stall();
    int i, st, stall_seen;
    bit take, seen1, trig, got_done;
    clear_writes();
    src = '{32'hA0A0A0A1, 32'hB0B0B0B2, 32'hC0C0C0C3};
    i = 0; st = 0; stall_seen = 0; seen1 = 0; got_done = 0;
    @(posedge clk); #1;
    base_addr = 16'h0200; num_words = 16'd3; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.opsum_valid = 1'b1; bus.opsum_data = src[0];
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin got_done = 1; break; end
      if (bus.glb_stall) begin
        stall_seen++;
        tests++;
        if (bus.glb_we !== 1'b1 || bus.glb_addr !== 16'h0204 || bus.glb_wdata !== src[1]
            || bus.opsum_ready !== 1'b0) begin
          fails++; $display("FAIL stall_hold: we %b addr %h data %h ready %b want 1 0204 %h 0",
                            bus.glb_we, bus.glb_addr, bus.glb_wdata, bus.opsum_ready, src[1]);
        end
      end
      take = bus.opsum_valid && bus.opsum_ready;
      trig = !seen1 && bus.glb_we && !bus.glb_stall && bus.glb_addr == 16'h0200;
      @(posedge clk); #1;
      if (take) i++;
      bus.opsum_valid = (i < 3);
      bus.opsum_data  = src[(i < 3) ? i : 0];
      if (trig) begin seen1 = 1; st = 3; end
      else if (st > 0) st--;
      bus.glb_stall = (st > 0);
    end
    bus.opsum_valid = 1'b0; bus.glb_stall = 1'b0;
    tests++;
    if (stall_seen != 3) begin fails++; $display("FAIL stall_cycles: got %0d want 3", stall_seen); end
    tests++;
    if (!got_done || busy !== 1'b0) begin fails++; $display("FAIL stall_done: done %b busy %b", got_done, busy); end
    tests++;
    if (wq_addr.size() != 3) begin fails++; $display("FAIL stall_count: got %0d want 3", wq_addr.size()); end
    for (int k = 0; k < wq_addr.size() && k < 3; k++) begin
      tests++;
      if (wq_addr[k] !== exp_addr(16'h0200, k) || wq_data[k] !== src[k]) begin
        fails++; $display("FAIL stall_word%0d: got %h/%h want %h/%h", k, wq_addr[k], wq_data[k],
                          exp_addr(16'h0200, k), src[k]);
      end
    end
  endtask

  task automatic test_relu();
    int lat, dcyc;
    clear_writes();
    src = '{32'hFFFFFFF6, 32'h0000000A};
    drive_job(16'h0300, 16'd2, 1'b1, 20, 80, -1, lat, dcyc);
    src = '{32'hFFFFFFF6};
    drive_job(16'h0310, 16'd1, 1'b0, 0, 100, -1, lat, dcyc);
    tests++;
    if (wq_data.size() != 3) begin fails++; $display("FAIL relu_count: got %0d want 3", wq_data.size()); end
    else begin
      tests++;
      if (wq_data[0] !== 32'h0 || wq_data[1] !== 32'h0000000A || wq_data[2] !== 32'hFFFFFFF6) begin
        fails++; $display("FAIL relu_data: got %h %h %h want 00000000 0000000a fffffff6",
                          wq_data[0], wq_data[1], wq_data[2]);
      end
    end
  endtask

  task automatic test_zero_wrap();
    int lat, dcyc;
    clear_writes();
    src.delete();
    drive_job(16'h0040, 16'd0, 1'b0, 0, 100, -1, lat, dcyc);
    tests++;
    if (lat != 0 || busy !== 1'b0) begin fails++; $display("FAIL zero_done: latency %0d busy %b want 0 0", lat, busy); end
    repeat (3) @(negedge clk);
    tests++;
    if (wq_addr.size() != 0 || done !== 1'b1) begin
      fails++; $display("FAIL zero_nowrite: writes %0d done %b want 0 1", wq_addr.size(), done);
    end
    src = '{32'h01020304, 32'h05060708};
    drive_job(16'hFFFE, 16'd2, 1'b0, 0, 100, -1, lat, dcyc);
    tests++;
    if (wq_addr.size() != 2 || wq_addr[0] !== 16'hFFFC || wq_addr[1] !== 16'h0000) begin
      fails++; $display("FAIL wrap_addr: %0d writes, want fffc then 0000", wq_addr.size());
    end
  endtask

  task automatic test_restart();
    int lat, dcyc;
    clear_writes();
    src = '{32'h9, 32'h8, 32'h7, 32'h6};
    drive_job(16'h0600, 16'd4, 1'b0, 0, 100, 1, lat, dcyc);
    tests++;
    if (wq_addr.size() != 4) begin fails++; $display("FAIL restart_count: got %0d want 4", wq_addr.size()); end
    for (int i = 0; i < wq_addr.size() && i < 4; i++) begin
      tests++;
      if (wq_addr[i] !== exp_addr(16'h0600, i) || wq_data[i] !== src[i]) begin
        fails++; $display("FAIL restart_word%0d: got %h/%h want %h/%h", i, wq_addr[i], wq_data[i],
                          exp_addr(16'h0600, i), src[i]);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int i, lat, dcyc;
    bit take;
    clear_writes();
    src = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
    i = 0;
    @(posedge clk); #1;
    base_addr = 16'h0400; num_words = 16'd5; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.opsum_valid = 1'b1; bus.opsum_data = src[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.glb_we && !bus.glb_stall && bus.glb_addr == 16'h0404) break;
      take = bus.opsum_valid && bus.opsum_ready;
      @(posedge clk); #1;
      if (take) i++;
      bus.opsum_valid = (i < 5);
      bus.opsum_data  = src[(i < 5) ? i : 0];
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.glb_stall = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({bus.opsum_ready, bus.glb_we, bus.glb_bwe, busy, done} !== 8'h0
        || bus.glb_addr !== 16'h0 || bus.glb_wdata !== 32'h0) begin
      fails++; $display("FAIL midrst_outputs: ctrl %b addr %h data %h want all 0",
                        {bus.opsum_ready, bus.glb_we, bus.glb_bwe, busy, done}, bus.glb_addr, bus.glb_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.glb_stall = 1'b0; bus.opsum_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.opsum_valid = 1'b0;
    tests++;
    if (wq_addr.size() != 2) begin fails++; $display("FAIL midrst_nowrite: got %0d writes want 2", wq_addr.size()); end
    clear_writes();
    src = '{32'h61, 32'hFFFFFF62, 32'h63, 32'h64, 32'h65};
    drive_job(16'h0500, 16'd5, 1'b1, 20, 80, -1, lat, dcyc);
    tests++;
    if (wq_addr.size() != 5) begin fails++; $display("FAIL postrst_count: got %0d want 5", wq_addr.size()); end
    for (int k = 0; k < wq_addr.size() && k < 5; k++) begin
      tests++;
      if (wq_addr[k] !== exp_addr(16'h0500, k) || wq_data[k] !== exp_data(src[k], 1'b1)) begin
        fails++; $display("FAIL postrst_word%0d: got %h/%h want %h/%h", k, wq_addr[k], wq_data[k],
                          exp_addr(16'h0500, k), exp_data(src[k], 1'b1));
      end
    end
  endtask

  task automatic test_random();
    int lat, dcyc, n;
    logic [15:0] base, a;
    logic relu;
    for (int j = 0; j < 8; j++) begin
      clear_writes();
      base = 16'($urandom);
      n    = $urandom_range(1, 8);
      relu = 1'($urandom_range(1));
      src.delete();
      for (int k = 0; k < n; k++) src.push_back($urandom);
      drive_job(base, 16'(n), relu, 30, 70, -1, lat, dcyc);
      @(negedge clk);
      tests++;
      if (wq_addr.size() != n) begin fails++; $display("FAIL rand%0d_count: got %0d want %0d", j, wq_addr.size(), n); end
      for (int k = 0; k < wq_addr.size() && k < n; k++) begin
        a = exp_addr(base, k);
        tests++;
        if (wq_addr[k] !== a || {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]}
            !== exp_data(src[k], relu)) begin
          fails++; $display("FAIL rand%0d_word%0d: addr %h want %h, glb %h%h%h%h want %h", j, k,
                            wq_addr[k], a, mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a],
                            exp_data(src[k], relu));
        end
      end
      tests++;
      if (wq_cyc.size() == 0 || dcyc != wq_cyc[wq_cyc.size()-1] + 1) begin
        fails++; $display("FAIL rand%0d_done: done cycle %0d not right after last write", j, dcyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_relu();
    test_zero_wrap();
    test_restart();
    test_reset_midjob();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/opsum_glb_writer.md
Name: opsum_glb_writer

Overview:
- Write-back engine that drains the PE-array output-psum stream into the global buffer (GLB).
- Accepts 32-bit opsums over a valid/ready handshake and writes each one as a little-endian word at base_addr + 4*index.
- Signals completion to Top, so Top can raise done once the opsum region in GLB is final.
- Handles GLB back-pressure, optional ReLU, zero-length jobs and restart.

Parameters:
- DATA_W, 32, opsum width; must equal GLB word width.
- ADDR_W, 16, GLB byte-address width.
- CNT_W, 16, width of the opsum count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle job start pulse.
- base_addr  input  ADDR_W  byte address of the first opsum; bits [1:0] ignored (forced 0).
- num_words  input  CNT_W  number of opsums in the job.
- relu_en  input  1  clamp negative opsums to 0.
- opsum_valid  input  1  opsum_data valid.
- opsum_ready  output  1  writer can accept an opsum.
- opsum_data  input  DATA_W  signed opsum.
- glb_we  output  1  GLB write request.
- glb_bwe  output  4  byte write enables.
- glb_addr  output  ADDR_W  GLB byte address.
- glb_wdata  output  DATA_W  write data; [7:0] goes to glb_addr, [31:24] to glb_addr+3.
- glb_stall  input  1  GLB cannot take a write this cycle.
- busy  output  1  job in progress.
- done  output  1  job complete; level.

Behaviour:
- Reset (synchronous): state IDLE. All outputs are 0: opsum_ready, glb_we, glb_bwe, glb_addr, glb_wdata, busy, done. Counters cleared.
- Reset mid-job: abort immediately; any pending write is dropped and never issued.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - latch base_addr & ~3, num_words and relu_en; clear idx; done<=0.
  - num_words==0: go to DONE, done=1 the next cycle; no GLB write.
  - otherwise go to RUN; busy=1 from the next cycle.
- RUN, handshake:
  - opsum_ready = !pend_full || write_accept, and only while accepted_cnt < num_words.
  - An opsum is accepted on opsum_valid && opsum_ready.
- RUN, write issue:
  - Accept in cycle N gives glb_we=1 in cycle N+1 with:
    - glb_addr = base + 4*idx, truncated mod 2^ADDR_W (wraps silently);
    - glb_bwe = 4'hF;
    - glb_wdata = (relu_en && data[31]) ? 0 : data.
  - One pending-write register; a write is accepted when glb_we && !glb_stall.
  - Full throughput with no stall: one opsum accepted and one word written per cycle, back-to-back.
- RUN, back-pressure:
  - While glb_stall=1: glb_we, glb_addr and glb_wdata are held stable, and opsum_ready=0 (pending register full).
  - idx increments only on write accept.
- RUN to DONE: on accept of write number num_words. The following cycle: glb_we=0, busy=0, done=1.
- DONE: done stays 1 until the next start or rst. The next start clears done and starts a new job.
- start in RUN: ignored; latched parameters unchanged.
- opsum_valid while not in RUN or at full count: ignored (ready=0).
- Arithmetic: idx has CNT_W bits; address = base + (idx<<2), computed in ADDR_W bits.

Test Plan:
- Basic job: base=0x0100, num=4, data 0x11111111, 0x22222222, 0x33333333, 0x44444444 with valid held high -> four writes on consecutive cycles, addresses 0x100, 0x104, 0x108, 0x10C; then done=1; GLB bytes at 0x100..0x103 read back as 11 11 11 11.
- Stall: num=3, glb_stall high for 3 cycles during write #2 (addr base+4) -> addr and data held stable for 3 cycles; opsum_ready=0 during the stall; exactly 3 writes total; done=1 afterwards.
- ReLU: relu_en=1, data 0xFFFFFFF6 (-10) then 0x0000000A -> written values 0x00000000 and 0x0000000A. With relu_en=0, 0xFFFFFFF6 is written unchanged.
- Zero / misaligned / wrap:
  - num=0 -> done=1 one cycle after start, no glb_we.
  - base=0xFFFE, num=2 -> addresses 0xFFFC then 0x0000.
- Restart and reset:
  - start asserted mid-job -> ignored.
  - rst asserted after 2 of 5 writes -> all outputs 0 the next cycle, no further writes.
  - A new start afterwards completes a full 5-word job correctly.
